sdp_group: RTL

- Next-generation dot-product group. N_UNIT lanes share one A operand. Each lane has N_MUL multipliers.
- Modes, selected per beat:
  - dense: A·B over N_MUL elements.
  - 2:4 structured-sparse: compressed A plus 2-bit indices gather from 2*N_MUL dense B elements.
- Multi-beat K accumulation (in_last terminates a tile), 3-stage pipeline, valid/ready on both sides with full backpressure.
- Sits between the operand buffers and the result writeback of the sparse tensor core.

---
 rtl/stc_pkg.sv | 32 +++
 rtl/sdp_group_if.sv | 31 +++
 rtl/sdp_lane.sv | 78 +++++++
 rtl/sdp_group.sv | 71 +++++++
 4 files changed

// File: rtl/stc_pkg.sv
// Shared sparse-tensor-core definitions: mode encodings, 2:4 group size and arithmetic helpers.
// sat_add is used by sdp_lane only when SDP_GROUP_SAT_EN is defined.
package stc_pkg;

   localparam logic MODE_DENSE    = 1'b0;
   localparam logic MODE_SPARSE24 = 1'b1;
   localparam int   GROUP         = 4;

   function automatic int clog2(input int v);
      int r;
      r = 0;
      for (int i = 0; i < 31; i++)
         if ((1 << r) < v) r = r + 1;
      return r;
   endfunction

   // Clamp x+y to the signed range of a w-bit word (w <= 62), result sign-extended to 64 bits.
   function automatic logic signed [63:0] sat_add(input logic signed [63:0] x,
                                                  input logic signed [63:0] y,
                                                  input int w);
      logic signed [63:0] s;
      logic signed [63:0] hi;
      logic signed [63:0] lo;
      s  = x + y;
      hi = (64'sd1 <<< (w - 1)) - 64'sd1;
      lo = -hi - 64'sd1;
      if (s > hi)      return hi;
      else if (s < lo) return lo;
      else             return s;
   endfunction

endpackage

// File: rtl/sdp_group_if.sv
// Beat-in / result-out handshake bundle of the dot-product group.
interface sdp_group_if #(
   parameter int N_UNIT = 4,
   parameter int N_MUL  = 4,
   parameter int DW_MUL = 8,
   parameter int DW_ADD = 32
);
   localparam int DW_UNIT_IN = DW_MUL * N_MUL;
   localparam int DW_B_UNIT  = 2 * DW_MUL * N_MUL;

   logic                         in_valid;
   logic                         in_ready;
   logic                         in_mode;
   logic                         in_last;
   logic [DW_UNIT_IN-1:0]        in_a;
   logic [2*N_MUL-1:0]           in_idx;
   logic [N_UNIT*DW_B_UNIT-1:0]  in_b;
   logic                         out_valid;
   logic                         out_ready;
   logic [N_UNIT*DW_ADD-1:0]     out;

   modport master (
      output in_valid, in_mode, in_last, in_a, in_idx, in_b, out_ready,
      input  in_ready, out_valid, out
   );

   modport slave (
      input  in_valid, in_mode, in_last, in_a, in_idx, in_b, out_ready,
      output in_ready, out_valid, out
   );
endinterface

// File: rtl/sdp_lane.sv
// One dot-product lane: operand select, product register, adder tree register, K accumulator.
// SDP_GROUP_SAT_EN selects a saturating accumulator instead of two's-complement wrap.
module sdp_lane
   import stc_pkg::*;
#(
   parameter int N_MUL  = 4,
   parameter int DW_MUL = 8,
   parameter int DW_ADD = 32
) (
   input  logic                        clk,
   input  logic                        reset,
   input  logic                        adv,
   input  logic                        v2,
   input  logic                        last2,
   input  logic                        mode,
   input  logic [N_MUL*DW_MUL-1:0]     a,
   input  logic [2*N_MUL-1:0]          idx,
   input  logic [2*N_MUL*DW_MUL-1:0]   b,
   output logic signed [DW_ADD-1:0]    res
);
   localparam int PW = 2 * DW_MUL;
   localparam int TW = PW + clog2(N_MUL);

   logic signed [DW_MUL-1:0] b_sel [N_MUL];
   logic signed [PW-1:0]     prod  [N_MUL];
   logic signed [TW-1:0]     tree_c;
   logic signed [TW-1:0]     tree_q;
   logic signed [DW_ADD-1:0] tree_ext;
   logic signed [DW_ADD-1:0] acc;
   logic signed [DW_ADD-1:0] sum;

   // Sparse: each A element picks its partner inside its own group of four B elements.
   always_comb begin
      for (int k = 0; k < N_MUL; k++) begin
         b_sel[k] = b[k*DW_MUL +: DW_MUL];
         case (mode)
            MODE_DENSE:    b_sel[k] = b[k*DW_MUL +: DW_MUL];
            MODE_SPARSE24: b_sel[k] = b[((k/2)*GROUP + int'(idx[2*k +: 2]))*DW_MUL +: DW_MUL];
         endcase
      end
   end

   always_comb begin
      tree_c = '0;
      for (int k = 0; k < N_MUL; k++)
         tree_c = tree_c + TW'(prod[k]);
   end

   assign tree_ext = DW_ADD'(tree_q);

`ifdef SDP_GROUP_SAT_EN
   assign sum = DW_ADD'(sat_add(64'(acc), 64'(tree_ext), DW_ADD));
`else
   assign sum = acc + tree_ext;
`endif

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         for (int k = 0; k < N_MUL; k++) prod[k] <= '0;
         tree_q <= '0;
         acc    <= '0;
         res    <= '0;
      end else if (adv) begin
         for (int k = 0; k < N_MUL; k++)
            prod[k] <= PW'($signed(a[k*DW_MUL +: DW_MUL])) * PW'(b_sel[k]);
         tree_q <= tree_c;
         if (v2) begin
            if (last2) begin
               res <= sum;
               acc <= '0;
            end else begin
               acc <= sum;
            end
         end
      end
   end

endmodule

// File: rtl/sdp_group.sv
// Dot-product group: N_UNIT lanes sharing A, lockstep 3-stage pipeline with full backpressure.
// Define SDP_GROUP_SAT_EN for saturating per-lane accumulation.
module sdp_group
   import stc_pkg::*;
#(
   parameter int N_UNIT = 4,
   parameter int N_MUL  = 4,
   parameter int DW_MUL = 8,
   parameter int DW_ADD = 32
) (
   input  logic        clk,
   input  logic        reset,
   sdp_group_if.slave  bus
);
   localparam int DW_B_UNIT = 2 * DW_MUL * N_MUL;

   logic adv;
   logic v1, last1;
   logic v2, last2;
   logic out_valid_q;
   logic signed [DW_ADD-1:0] lane_res [N_UNIT];
   logic [N_UNIT*DW_ADD-1:0] out_w;

   // Only a held, unaccepted result can stall; everything else moves every cycle.
   assign adv           = !(out_valid_q && !bus.out_ready);
   assign bus.in_ready  = adv;
   assign bus.out_valid = out_valid_q;
   assign bus.out       = out_w;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         v1          <= 1'b0;
         last1       <= 1'b0;
         v2          <= 1'b0;
         last2       <= 1'b0;
         out_valid_q <= 1'b0;
      end else if (adv) begin
         v1          <= bus.in_valid;
         last1       <= bus.in_valid && bus.in_last;
         v2          <= v1;
         last2       <= last1;
         out_valid_q <= v2 && last2;
      end
   end

   for (genvar i = 0; i < N_UNIT; i++) begin : g_lane
      sdp_lane #(
         .N_MUL  (N_MUL),
         .DW_MUL (DW_MUL),
         .DW_ADD (DW_ADD)
      ) u_lane (
         .clk   (clk),
         .reset (reset),
         .adv   (adv),
         .v2    (v2),
         .last2 (last2),
         .mode  (bus.in_mode),
         .a     (bus.in_a),
         .idx   (bus.in_idx),
         .b     (bus.in_b[i*DW_B_UNIT +: DW_B_UNIT]),
         .res   (lane_res[i])
      );
   end

   always_comb begin
      out_w = '0;
      for (int i = 0; i < N_UNIT; i++)
         out_w[i*DW_ADD +: DW_ADD] = lane_res[i];
   end

endmodule
